// File: rtl/gray_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module   : gray_seq_counter
//  Brief    : Up/down binary counter with registered Gray-code output,
//             synchronous load, terminal-count, wrap pulse and optional
//             halt-at-terminal mode.
//  Revision : 1.0  initial release
// ============================================================================
module gray_seq_counter #(
    parameter int WIDTH       = 3,
    parameter int STOP_AT_END = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap,
    output logic             halted
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [0:0]       r_state;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_bin_step;
    logic             w_wrap_next;
    logic [0:0]       w_state_next;
    logic             w_tc;

    // Terminal count depends on the direction currently requested.
    always_comb begin
        w_tc = up_dn ? (r_bin == c_ALL_ONES) : (r_bin == c_ZERO);
    end

    // Next-state selection: load beats enable, enable beats hold.
    always_comb begin
        w_bin_step   = up_dn ? (r_bin + c_ONE) : (r_bin - c_ONE);
        w_bin_next   = r_bin;
        w_wrap_next  = 1'b0;
        w_state_next = r_state;
        if (load) begin
            w_bin_next   = load_bin;
            w_state_next = S_RUN;
        end else if (en && (r_state == S_RUN)) begin
            if (w_tc && (STOP_AT_END != 0)) begin
                // Hold the terminal value and park until the next load.
                w_state_next = S_HALT;
            end else begin
                // Modulo arithmetic makes the wrap step fall out naturally.
                w_bin_next  = w_bin_step;
                w_wrap_next = w_tc;
            end
        end
    end

    // Binary and Gray registers share one edge so they can never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin   <= c_ZERO;
            r_gray  <= c_ZERO;
            r_wrap  <= 1'b0;
            r_state <= S_RUN;
        end else begin
            r_bin   <= w_bin_next;
            r_gray  <= w_bin_next ^ (w_bin_next >> 1);
            r_wrap  <= w_wrap_next;
            r_state <= w_state_next;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign tc       = w_tc;
    assign wrap     = r_wrap;
    assign halted   = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_seq_counter
//  Brief    : Scoreboard bench for gray_seq_counter, wrap and halt variants
//             driven by the same stimulus side by side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gray_seq_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [2:0] load_bin;

    logic [2:0] bin_w, gray_w, bin_s, gray_s;
    logic       tc_w, wrap_w, halted_w, tc_s, wrap_s, halted_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] bin_w;
        logic [2:0] gray_w;
        logic       wrap_w;
        logic       halt_w;
        logic [2:0] bin_s;
        logic [2:0] gray_s;
        logic       wrap_s;
        logic       halt_s;
        logic       ld;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: index 0 = wrap variant, 1 = halt variant.
    int m_cnt  [2];
    bit m_halt [2];
    bit m_wrap [2];

    logic [2:0] prev_gray_w;
    logic [2:0] prev_gray_s;

    always #5 clk = ~clk;

    gray_seq_counter #(.WIDTH(3), .STOP_AT_END(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .bin_out(bin_w), .gray_out(gray_w), .tc(tc_w),
        .wrap(wrap_w), .halted(halted_w)
    );

    gray_seq_counter #(.WIDTH(3), .STOP_AT_END(1)) dut_stop (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .bin_out(bin_s), .gray_out(gray_s), .tc(tc_s),
        .wrap(wrap_s), .halted(halted_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reflected binary Gray code, listed by hand.
    function automatic logic [2:0] gray_of(input int v);
        case (v)
            0: gray_of = 3'b000;
            1: gray_of = 3'b001;
            2: gray_of = 3'b011;
            3: gray_of = 3'b010;
            4: gray_of = 3'b110;
            5: gray_of = 3'b111;
            6: gray_of = 3'b101;
            default: gray_of = 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_halt[i] = 1'b0;
            m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit e, input bit u, input bit l, input int lb);
        for (int i = 0; i < 2; i++) begin
            bit at_end;
            at_end    = u ? (m_cnt[i] == 7) : (m_cnt[i] == 0);
            m_wrap[i] = 1'b0;
            if (l) begin
                m_cnt[i]  = lb;
                m_halt[i] = 1'b0;
            end else if (e && !m_halt[i]) begin
                if (at_end && i == 1) begin
                    m_halt[i] = 1'b1;
                end else begin
                    m_cnt[i]  = u ? (m_cnt[i] + 1) % 8 : (m_cnt[i] + 7) % 8;
                    m_wrap[i] = at_end;
                end
            end
        end
    endtask

    // One stimulus cycle: drive at the falling edge, queue the post-edge result.
    task automatic step(input bit e, input bit u, input bit l, input logic [2:0] lb);
        exp_t x;
        @(negedge clk);
        en = e; up_dn = u; load = l; load_bin = lb;
        #1;
        chk("tc_wrapvar", 32'(tc_w), 32'(u ? (m_cnt[0] == 7) : (m_cnt[0] == 0)));
        chk("tc_stopvar", 32'(tc_s), 32'(u ? (m_cnt[1] == 7) : (m_cnt[1] == 0)));
        model_edge(e, u, l, int'(lb));
        x.bin_w  = 3'(m_cnt[0]);
        x.gray_w = gray_of(m_cnt[0]);
        x.wrap_w = m_wrap[0];
        x.halt_w = m_halt[0];
        x.bin_s  = 3'(m_cnt[1]);
        x.gray_s = gray_of(m_cnt[1]);
        x.wrap_s = m_wrap[1];
        x.halt_s = m_halt[1];
        x.ld     = l;
        exp_q.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bin_w"},  32'(bin_w),    32'd0);
        chk({tag, "_gray_w"}, 32'(gray_w),   32'd0);
        chk({tag, "_wrap_w"}, 32'(wrap_w),   32'd0);
        chk({tag, "_bin_s"},  32'(bin_s),    32'd0);
        chk({tag, "_gray_s"}, 32'(gray_s),   32'd0);
        chk({tag, "_halt_s"}, 32'(halted_s), 32'd0);
    endtask

    // Reset asserted in the middle of the high phase, away from any edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        en = 1'b0; load = 1'b0;
        chk("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t x;
        prev_gray_w = 3'b000;
        prev_gray_s = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("bin_wrapvar",    32'(bin_w),    32'(x.bin_w));
                chk("gray_wrapvar",   32'(gray_w),   32'(x.gray_w));
                chk("wrap_wrapvar",   32'(wrap_w),   32'(x.wrap_w));
                chk("halted_wrapvar", 32'(halted_w), 32'(x.halt_w));
                chk("bin_stopvar",    32'(bin_s),    32'(x.bin_s));
                chk("gray_stopvar",   32'(gray_s),   32'(x.gray_s));
                chk("wrap_stopvar",   32'(wrap_s),   32'(x.wrap_s));
                chk("halted_stopvar", 32'(halted_s), 32'(x.halt_s));
                if (!x.ld && gray_w != prev_gray_w)
                    chk("single_bit_wrapvar", 32'($countones(gray_w ^ prev_gray_w)), 32'd1);
                if (!x.ld && gray_s != prev_gray_s)
                    chk("single_bit_stopvar", 32'($countones(gray_s ^ prev_gray_s)), 32'd1);
            end
            prev_gray_w = gray_w;
            prev_gray_s = gray_s;
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 3'd0;
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full up sequence through the wrap back to zero.
        repeat (9) step(1'b1, 1'b1, 1'b0, 3'd0);

        // Count down from reset: first step wraps to all-ones.
        async_reset();
        repeat (4) step(1'b1, 1'b0, 1'b0, 3'd0);

        // Load wins over enable, then a normal up step.
        step(1'b1, 1'b1, 1'b1, 3'd5);
        step(1'b1, 1'b1, 1'b0, 3'd0);

        // Halt at terminal count, direction toggle, release by load.
        step(1'b0, 1'b1, 1'b1, 3'd0);
        repeat (9) step(1'b1, 1'b1, 1'b0, 3'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b0, 3'd0);

        // Load at terminal count, halt, then asynchronous reset clears it.
        step(1'b0, 1'b1, 1'b1, 3'd7);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        async_reset();

        // Asynchronous reset from a count of 4.
        step(1'b0, 1'b1, 1'b1, 3'd4);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        async_reset();

        // Randomised traffic.
        for (int k = 0; k < 1000; k++) begin
            step(($urandom_range(3) != 0), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0), 3'($urandom_range(7)));
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
